// File: rtl/nibble_program_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_program_feeder_if
//  Description : Host/consumer bundle for the nibble program feeder.
//                Carries the load handshake, the run/stop/clear commands,
//                the replay valid/ready stream and the status flags.
//                master : host / consumer side (drives loads, commands, ready)
//                slave  : feeder side (drives load_ready, replay, status)
//  Revision    : 1.0  initial release
// ============================================================================
interface nibble_program_feeder_if #(
    parameter int AW = 4
);
    logic          load_valid;
    logic [3:0]    load_nib;
    logic          load_ready;
    logic          cmd_clear;
    logic          cmd_run;
    logic          cmd_stop;
    logic          loop_en;
    logic [3:0]    out_nib;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          overflow;

    modport master (
        output load_valid, load_nib, cmd_clear, cmd_run, cmd_stop, loop_en, out_ready,
        input  load_ready, out_nib, out_valid, count, busy, done, overflow
    );

    modport slave (
        input  load_valid, load_nib, cmd_clear, cmd_run, cmd_stop, loop_en, out_ready,
        output load_ready, out_nib, out_valid, count, busy, done, overflow
    );
endinterface
`default_nettype wire

// File: rtl/nibble_program_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_program_feeder
//  Description : Stores a host-loaded nibble program (opcodes + operands) and
//                replays it in order on a valid/ready nibble stream feeding
//                the 4-bit stack CPU input field.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - nibble_program_feeder_if.slave: load handshake,
//                       cmd_clear/cmd_run/cmd_stop, loop_en, replay stream
//                       (out_nib/out_valid/out_ready), count, busy, done,
//                       overflow
//  Config      : define NIBBLE_FEEDER_LOOP_EN to let loop_en wrap the replay
//                back to address 0 instead of finishing with done.
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_program_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    nibble_program_feeder_if.slave    bus
);
    localparam logic [0:0]  c_ST_IDLE   = 1'b0;
    localparam logic [0:0]  c_ST_RUN    = 1'b1;
    localparam logic [AW:0] c_DEPTH_CNT = (AW+1)'(DEPTH);

    logic [3:0]     r_mem [DEPTH];
    logic [0:0]     r_state;
    logic [0:0]     w_state_nxt;
    logic [AW:0]    r_count;
    logic [AW-1:0]  r_rd_ptr;
    logic [3:0]     r_out_nib;
    logic           r_out_valid;
    logic           r_done;
    logic           r_overflow;

    logic           w_beat;
    logic           w_last;
    logic           w_full;
    logic           w_loop;
    logic           w_load_ready;
    logic           w_load_fire;
    logic [AW-1:0]  w_rd_next;

    assign w_beat      = r_out_valid & bus.out_ready;
    // count >= 1 whenever in RUN, so count-1 never underflows where it matters
    assign w_last      = ({1'b0, r_rd_ptr} == (r_count - 1'b1));
    assign w_full      = (r_count == c_DEPTH_CNT);
    assign w_rd_next   = r_rd_ptr + 1'b1;
    assign w_load_fire = bus.load_valid & w_load_ready;

`ifdef NIBBLE_FEEDER_LOOP_EN
    assign w_loop = bus.loop_en;
`else
    // Looping is compiled out: loop_en has no effect.
    assign w_loop = bus.loop_en & 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!bus.cmd_clear && bus.cmd_run && (r_count != '0))
                    w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (bus.cmd_stop)
                    w_state_nxt = c_ST_IDLE;
                else if (w_beat && w_last && !w_loop)
                    w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        w_load_ready = (r_state == c_ST_IDLE) && !w_full && !bus.cmd_run && !bus.cmd_clear;
    end

    assign bus.load_ready = w_load_ready;
    assign bus.out_nib    = r_out_nib;
    assign bus.out_valid  = r_out_valid;
    assign bus.count      = r_count;
    assign bus.busy       = (r_state == c_ST_RUN);
    assign bus.done       = r_done;
    assign bus.overflow   = r_overflow;

    // ---------------- program storage (not cleared by reset) ----------------
    always_ff @(posedge clk) begin
        if (w_load_fire && !rst)
            r_mem[r_count[AW-1:0]] <= bus.load_nib;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_out_nib   <= 4'h0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.cmd_clear) begin
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end else if (bus.cmd_run) begin
                        if (r_count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_rd_ptr    <= '0;
                            r_out_nib   <= r_mem[0];
                            r_out_valid <= 1'b1;
                        end
                    end else if (w_load_fire) begin
                        r_count <= r_count + 1'b1;
                    end else if (bus.load_valid && w_full) begin
                        r_overflow <= 1'b1;
                    end
                end
                c_ST_RUN: begin
                    // Stop wins: a coincident beat is simply the last one taken.
                    if (bus.cmd_stop) begin
                        r_out_valid <= 1'b0;
                    end else if (w_beat) begin
                        if (!w_last) begin
                            r_rd_ptr  <= w_rd_next;
                            r_out_nib <= r_mem[w_rd_next];
                        end else if (w_loop) begin
                            r_rd_ptr  <= '0;
                            r_out_nib <= r_mem[0];
                        end else begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_nibble_program_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_program_feeder
//  Description : Directed self-checking bench for nibble_program_feeder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_program_feeder;
    logic clk;
    logic rst;
    int   n_err;
    int   n_chk;

    nibble_program_feeder_if #(.AW(4)) bus ();

    nibble_program_feeder #(.DEPTH(16), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_nibs(input int n, input logic [63:0] nibs);
        for (int i = 0; i < n; i++) begin
            bus.load_valid = 1'b1;
            bus.load_nib   = nibs[4*i +: 4];
            step();
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic do_cmd_run();
        bus.cmd_run = 1'b1;
        step();
        bus.cmd_run = 1'b0;
    endtask

    task automatic do_clear();
        bus.cmd_clear = 1'b1;
        step();
        bus.cmd_clear = 1'b0;
    endtask

    // Expects replay already started with out_ready=1; checks every beat, then done.
    task automatic run_expect(input string tag, input int n, input logic [63:0] nibs);
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
            check_eq({tag, "_nib"},   32'(bus.out_nib),   32'(nibs[4*i +: 4]));
            check_eq({tag, "_nodone"}, 32'(bus.done),     32'd0);
            step();
        end
        check_eq({tag, "_done"},     32'(bus.done),      32'd1);
        check_eq({tag, "_endvalid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_endbusy"},  32'(bus.busy),      32'd0);
        step();
        check_eq({tag, "_donepulse"}, 32'(bus.done),     32'd0);
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        rst   = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_nib   = 4'h0;
        bus.cmd_clear  = 1'b0;
        bus.cmd_run    = 1'b0;
        bus.cmd_stop   = 1'b0;
        bus.loop_en    = 1'b0;
        bus.out_ready  = 1'b1;
        step();
        step();

        // ---- reset state ----
        check_eq("rst_valid",    32'(bus.out_valid),  32'd0);
        check_eq("rst_nib",      32'(bus.out_nib),    32'd0);
        check_eq("rst_count",    32'(bus.count),      32'd0);
        check_eq("rst_busy",     32'(bus.busy),       32'd0);
        check_eq("rst_done",     32'(bus.done),       32'd0);
        check_eq("rst_ovf",      32'(bus.overflow),   32'd0);
        check_eq("rst_ldready",  32'(bus.load_ready), 32'd1);
        rst = 1'b0;
        step();

        // ---- 1: load 1,5,1,3,3 and replay back to back ----
        load_nibs(5, 64'h33151);
        check_eq("t1_count", 32'(bus.count), 32'd5);
        do_cmd_run();
        check_eq("t1_busy", 32'(bus.busy), 32'd1);
        run_expect("t1", 5, 64'h33151);

        // ---- 2: fill to DEPTH, overflow, full replay, clear ----
        do_clear();
        load_nibs(16, 64'hFEDCBA9876543210);
        check_eq("t2_count",   32'(bus.count),      32'd16);
        check_eq("t2_ldready", 32'(bus.load_ready), 32'd0);
        check_eq("t2_noovf",   32'(bus.overflow),   32'd0);
        load_nibs(1, 64'hA);
        check_eq("t2_ovf",     32'(bus.overflow),   32'd1);
        check_eq("t2_count16", 32'(bus.count),      32'd16);
        do_cmd_run();
        run_expect("t2", 16, 64'hFEDCBA9876543210);
        check_eq("t2_ovfsticky", 32'(bus.overflow), 32'd1);
        do_clear();
        check_eq("t2_clrcount", 32'(bus.count),    32'd0);
        check_eq("t2_clrovf",   32'(bus.overflow), 32'd0);

        // ---- 3: backpressure holds the first nibble ----
        load_nibs(2, 64'h72);
        bus.out_ready = 1'b0;
        do_cmd_run();
        for (int i = 0; i < 4; i++) begin
            check_eq("t3_hold_valid", 32'(bus.out_valid), 32'd1);
            check_eq("t3_hold_nib",   32'(bus.out_nib),   32'd2);
            step();
        end
        bus.out_ready = 1'b1;
        run_expect("t3", 2, 64'h72);

        // ---- 4: stop mid-replay, re-run restarts at mem[0] ----
        do_clear();
        load_nibs(4, 64'h4689);
        do_cmd_run();
        check_eq("t4_nib0", 32'(bus.out_nib), 32'd9);
        step();
        check_eq("t4_nib1", 32'(bus.out_nib), 32'd8);
        step();
        check_eq("t4_nib2", 32'(bus.out_nib), 32'd6);
        bus.out_ready = 1'b0;
        bus.cmd_stop  = 1'b1;
        step();
        bus.cmd_stop  = 1'b0;
        check_eq("t4_stopvalid", 32'(bus.out_valid), 32'd0);
        check_eq("t4_stopdone",  32'(bus.done),      32'd0);
        check_eq("t4_stopbusy",  32'(bus.busy),      32'd0);
        check_eq("t4_stopcount", 32'(bus.count),     32'd4);
        bus.out_ready = 1'b1;
        do_cmd_run();
        run_expect("t4", 4, 64'h4689);

        // ---- 5: run on empty program, reset during replay ----
        do_clear();
        do_cmd_run();
        check_eq("t5_emptydone",  32'(bus.done),      32'd1);
        check_eq("t5_emptyvalid", 32'(bus.out_valid), 32'd0);
        check_eq("t5_emptybusy",  32'(bus.busy),      32'd0);
        step();
        check_eq("t5_emptypulse", 32'(bus.done),      32'd0);
        check_eq("t5_emptyvalid2", 32'(bus.out_valid), 32'd0);
        load_nibs(3, 64'h123);
        bus.out_ready = 1'b0;
        do_cmd_run();
        check_eq("t5_runbusy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t5_rstvalid", 32'(bus.out_valid), 32'd0);
        check_eq("t5_rstcount", 32'(bus.count),     32'd0);
        check_eq("t5_rstbusy",  32'(bus.busy),      32'd0);
        bus.out_ready = 1'b1;

        // ---- 6: loop_en behaviour ----
        load_nibs(2, 64'h21);
        bus.loop_en = 1'b1;
        do_cmd_run();
`ifdef NIBBLE_FEEDER_LOOP_EN
        for (int i = 0; i < 6; i++) begin
            check_eq("t6_loopvalid", 32'(bus.out_valid), 32'd1);
            check_eq("t6_loopnib",   32'(bus.out_nib),   (i % 2 == 0) ? 32'd1 : 32'd2);
            check_eq("t6_loopdone",  32'(bus.done),      32'd0);
            step();
        end
        bus.cmd_stop = 1'b1;
        step();
        bus.cmd_stop = 1'b0;
        check_eq("t6_stopvalid", 32'(bus.out_valid), 32'd0);
        check_eq("t6_stopdone",  32'(bus.done),      32'd0);
        check_eq("t6_stopbusy",  32'(bus.busy),      32'd0);
`else
        run_expect("t6", 2, 64'h21);
`endif
        bus.loop_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
